// File: rtl/tao_ifu_pkg.sv
// Shared types, constants and helpers for the tao instruction fetch unit.
package tao_ifu_pkg;

  localparam int          TAO_SIZE_BUS = 32;
  localparam int          TMO_W        = 8;
  localparam logic [31:0] RESET_PC     = 32'h8000_0000;
  localparam logic [7:0]  TIMEOUT_CYC  = 8'd255;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_IDLE = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_OUT  = 3'd4
  } ifu_state_e;

  // A fetch address that is not word aligned cannot be fetched at all.
  function automatic logic pc_misaligned(input logic [TAO_SIZE_BUS-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  // Faulted responses never leak bus data toward decode.
  function automatic logic [TAO_SIZE_BUS-1:0] fetch_inst(input logic [TAO_SIZE_BUS-1:0] rdata,
                                                         input logic                    err);
    return err ? 32'h0000_0000 : rdata;
  endfunction

endpackage

// File: rtl/tao_ifu_tmo.sv
// Fetch timeout counter: clears on request entry, counts while a fetch is
// pending and saturates so it can never wrap back into the "alive" range.
module tao_ifu_tmo
  import tao_ifu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TMO_W-1:0] r_cnt;

  // Cycle counter with clear priority and saturation at the timeout limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en && (r_cnt != TIMEOUT_CYC)) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (r_cnt == TIMEOUT_CYC);

endmodule

// File: rtl/tao_ifu.sv
// Instruction fetch unit: issues one instruction-memory read per fetch
// address, bounds the wait with a timeout and hands a packet to decode.
module tao_ifu
  import tao_ifu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TAO_SIZE_BUS-1:0] i_pc,
  input  logic                    i_pc_vld,
  output logic                    imem_req,
  output logic [TAO_SIZE_BUS-1:0] imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [TAO_SIZE_BUS-1:0] imem_rdata,
  input  logic                    imem_err,
  output logic                    ifu_vld,
  input  logic                    ifu_rdy,
  output logic [TAO_SIZE_BUS-1:0] ifu_pc,
  output logic [TAO_SIZE_BUS-1:0] ifu_inst,
  output logic                    ifu_err
);

  ifu_state_e              r_state;
  logic [TAO_SIZE_BUS-1:0] r_pc;
  logic                    r_orphan;
  logic                    r_imem_req;
  logic [TAO_SIZE_BUS-1:0] r_imem_addr;
  logic                    r_ifu_vld;
  logic [TAO_SIZE_BUS-1:0] r_ifu_pc;
  logic [TAO_SIZE_BUS-1:0] r_ifu_inst;
  logic                    r_ifu_err;

  logic                    w_hs;
  logic                    w_take_pc;
  logic                    w_pc_mis;
  logic                    w_orph_next;
  logic                    w_tmo_clr;
  logic                    w_tmo_en;
  logic                    w_tmo_exp;
  logic [TAO_SIZE_BUS-1:0] w_rsp_inst;

  // A new pc is only taken in IDLE or together with a completed handshake.
  assign w_hs        = (r_state == ST_OUT) && ifu_rdy;
  assign w_take_pc   = i_pc_vld && ((r_state == ST_IDLE) || w_hs);
  assign w_pc_mis    = pc_misaligned(i_pc);
  // The orphan flag as it will be next cycle: a late response clears it.
  assign w_orph_next = r_orphan && !imem_rvalid;
  assign w_tmo_clr   = (r_state == ST_BOOT) || (w_take_pc && !w_pc_mis);
  assign w_tmo_en    = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign w_rsp_inst  = fetch_inst(imem_rdata, imem_err);

  tao_ifu_tmo u_tmo (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmo_clr),
    .i_en      (w_tmo_en),
    .o_expired (w_tmo_exp)
  );

  // Fetch sequencer with all bus and packet outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_orphan    <= 1'b0;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_ifu_vld   <= 1'b0;
      r_ifu_pc    <= RESET_PC;
      r_ifu_inst  <= 32'h0000_0000;
      r_ifu_err   <= 1'b0;
    end else begin
      if (r_orphan && imem_rvalid) begin
        r_orphan <= 1'b0;
      end
      case (r_state)
        ST_BOOT: begin
          r_state     <= ST_REQ;
          r_pc        <= RESET_PC;
          r_imem_addr <= RESET_PC;
          r_imem_req  <= !w_orph_next;
        end
        ST_IDLE, ST_OUT: begin
          if (w_take_pc) begin
            r_pc        <= i_pc;
            r_imem_addr <= i_pc;
            if (w_pc_mis) begin
              r_state    <= ST_OUT;
              r_imem_req <= 1'b0;
              r_ifu_vld  <= 1'b1;
              r_ifu_pc   <= i_pc;
              r_ifu_inst <= 32'h0000_0000;
              r_ifu_err  <= 1'b1;
            end else begin
              r_state    <= ST_REQ;
              r_imem_req <= !w_orph_next;
              r_ifu_vld  <= 1'b0;
            end
          end else if (w_hs) begin
            r_state   <= ST_IDLE;
            r_ifu_vld <= 1'b0;
          end
        end
        ST_REQ: begin
          if (r_imem_req && imem_gnt && imem_rvalid) begin
            r_state    <= ST_OUT;
            r_imem_req <= 1'b0;
            r_ifu_vld  <= 1'b1;
            r_ifu_pc   <= r_pc;
            r_ifu_inst <= w_rsp_inst;
            r_ifu_err  <= imem_err;
          end else if (r_imem_req && imem_gnt) begin
            r_state    <= ST_WAIT;
            r_imem_req <= 1'b0;
          end else if (w_tmo_exp) begin
            r_state    <= ST_OUT;
            r_imem_req <= 1'b0;
            r_ifu_vld  <= 1'b1;
            r_ifu_pc   <= r_pc;
            r_ifu_inst <= 32'h0000_0000;
            r_ifu_err  <= 1'b1;
          end else begin
            r_imem_req <= !w_orph_next;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            r_state    <= ST_OUT;
            r_ifu_vld  <= 1'b1;
            r_ifu_pc   <= r_pc;
            r_ifu_inst <= w_rsp_inst;
            r_ifu_err  <= imem_err;
          end else if (w_tmo_exp) begin
            r_state    <= ST_OUT;
            r_orphan   <= 1'b1;
            r_ifu_vld  <= 1'b1;
            r_ifu_pc   <= r_pc;
            r_ifu_inst <= 32'h0000_0000;
            r_ifu_err  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign ifu_vld   = r_ifu_vld;
  assign ifu_pc    = r_ifu_pc;
  assign ifu_inst  = r_ifu_inst;
  assign ifu_err   = r_ifu_err;

endmodule
